// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle ARM-subset core: sequences fetch, decode,
// execute, memory and writeback, and decodes ALU control from Funct.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       Mov,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;

  localparam logic [3:0] WaitMax = 4'(MEM_WAIT);

  state_e     r_state;
  logic [3:0] r_wait_cnt;

  // Codes 10..15 fall into the default arm and return to fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StFetch;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        StFetch:  r_state <= StDecode;
        StDecode: begin
          unique case (Op)
            2'b00:   r_state <= Funct[5] ? StExecI : StExecR;
            2'b01:   r_state <= StMemAdr;
            2'b10:   r_state <= StBranch;
            default: r_state <= StFetch;
          endcase
        end
        StMemAdr: r_state <= Funct[0] ? StMemRead : StMemWrite;
        StMemRead: begin
          if (r_wait_cnt == WaitMax) begin
            r_state    <= StMemWb;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        StMemWb:    r_state <= StFetch;
        StMemWrite: r_state <= StFetch;
        StExecR:    r_state <= StAluWb;
        StExecI:    r_state <= StAluWb;
        StAluWb:    r_state <= StFetch;
        StBranch:   r_state <= StFetch;
        default: begin
          r_state    <= StFetch;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  logic       w_irwrite;
  logic       w_nextpc;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;
  logic       w_alu_dec;
  logic [2:0] w_alu_ctl;
  logic       w_mov;

  always_comb begin
    w_irwrite = 1'b0;
    w_nextpc  = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_branch  = 1'b0;
    w_alu_dec = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    unique case (r_state)
      StFetch: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = 1'b1;
        w_nextpc  = 1'b1;
      end
      StDecode: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr:   ALUSrcB = 2'b01;
      StMemRead:  AdrSrc  = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      StMemWrite: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      StExecR:    w_alu_dec = 1'b1;
      StExecI: begin
        ALUSrcB   = 2'b01;
        w_alu_dec = 1'b1;
      end
      StAluWb:    w_regw = 1'b1;
      StBranch: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_ctl = AluAdd;
    w_mov     = 1'b0;
    unique case (Funct[4:1])
      4'b0100: w_alu_ctl = AluAdd;
      4'b0010: w_alu_ctl = AluSub;
      4'b0000: w_alu_ctl = AluAnd;
      4'b1100: w_alu_ctl = AluOrr;
      4'b1101: w_mov     = 1'b1;
      default: w_alu_ctl = AluAdd;
    endcase
  end

  always_comb begin
    ALUControl = AluAdd;
    FlagW      = 2'b00;
    Mov        = 1'b0;
    if (w_alu_dec) begin
      ALUControl = w_alu_ctl;
      FlagW      = {Funct[0], Funct[0] & ((w_alu_ctl == AluAdd) | (w_alu_ctl == AluSub))};
      Mov        = w_mov;
    end
  end

  // Reset masks every write strobe so an abandoned instruction cannot commit.
  always_comb begin
    IRWrite = w_irwrite & ~reset;
    NextPC  = w_nextpc & ~reset;
    RegW    = w_regw & ~reset;
    MemW    = w_memw & ~reset;
    PCS     = (w_branch | (w_regw & (Rd == 4'b1111))) & ~reset;
  end

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign State  = r_state;

  a_no_dual_write: assert property (@(posedge clk) !(RegW && MemW));
  a_wait_bound:    assert property (@(posedge clk) disable iff (reset)
                                    (r_state == StMemRead) |-> (r_wait_cnt <= WaitMax));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle outputs are queued
// when an instruction is applied and compared each cycle on the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, NextPC, PCS, RegW, MemW, AdrSrc, Mov;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
  logic [2:0] ALUControl;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .Mov        (Mov),
    .State      (State)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       irw, npc, pcs, regw, memw, adr;
    logic [1:0] asa, asb, rs, imm, rsrc;
    logic [2:0] alu;
    logic [1:0] fw;
    logic       mov;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o = '{st: State, irw: IRWrite, npc: NextPC, pcs: PCS, regw: RegW, memw: MemW,
          adr: AdrSrc, asa: ALUSrcA, asb: ALUSrcB, rs: ResultSrc, imm: ImmSrc,
          rsrc: RegSrc, alu: ALUControl, fw: FlagW, mov: Mov};
    return o;
  endfunction

  // Expected outputs for a state, written from the control table.
  function automatic exp_t model(input logic [3:0] st, input logic [1:0] op,
                                 input logic [5:0] f, input logic [3:0] rd);
    exp_t e;
    e      = '0;
    e.st   = st;
    e.imm  = op;
    e.rsrc = {op == 2'b01, op == 2'b10};
    case (st)
      4'd0: begin e.asa = 2'b01; e.asb = 2'b10; e.rs = 2'b10; e.irw = 1; e.npc = 1; end
      4'd1: begin e.asa = 2'b01; e.asb = 2'b10; e.rs = 2'b10; end
      4'd2: e.asb = 2'b01;
      4'd3: e.adr = 1;
      4'd4: begin e.rs = 2'b01; e.regw = 1; end
      4'd5: begin e.adr = 1; e.memw = 1; end
      4'd6, 4'd7: begin
        e.asb = (st == 4'd7) ? 2'b01 : 2'b00;
        case (f[4:1])
          4'b0010: e.alu = 3'b001;
          4'b0000: e.alu = 3'b010;
          4'b1100: e.alu = 3'b011;
          4'b1101: e.mov = 1;
          default: e.alu = 3'b000;
        endcase
        e.fw = {f[0], f[0] && (e.alu == 3'b000 || e.alu == 3'b001)};
      end
      4'd8: e.regw = 1;
      4'd9: begin e.asa = 2'b10; e.asb = 2'b01; e.rs = 2'b10; e.pcs = 1; end
      default: ;
    endcase
    if (e.regw && rd == 4'hf) e.pcs = 1;
    return e;
  endfunction

  // Entered just after a rising edge; leaves just after the edge following seq[n-1].
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] seq [8], input int n);
    exp_t e;
    Op    = op;
    Funct = f;
    Rd    = rd;
    for (int i = 0; i < n; i++) sb_q.push_back(model(seq[i], op, f, rd));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check_val($sformatf("%s state[%0d]", name, i), 32'(State), 32'(e.st));
      check_val($sformatf("%s outs[%0d] st=%0d", name, i, e.st), 32'(observe()), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  // Runs a prefix into target state, then holds reset for two cycles.
  task automatic reset_mid(input string name, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] seq [8], input int n,
                           input logic [3:0] target);
    run_instr(name, op, f, rd, seq, n);
    reset = 1'b1;
    @(negedge clk);
    check_val({name, " rst state"}, 32'(State), 32'(target));
    check_val({name, " rst strobes"}, 32'({IRWrite, NextPC, RegW, MemW, PCS}), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val({name, " rst2 state"}, 32'(State), 32'h0);
    check_val({name, " rst2 strobes"}, 32'({IRWrite, NextPC, RegW, MemW, PCS}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    Op    = 2'b11;
    Funct = '0;
    Rd    = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("init rst strobes", 32'({IRWrite, NextPC, RegW, MemW, PCS}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr("nop0",  2'b11, 6'b000000, 4'h0, '{0, 1, 0, 0, 0, 0, 0, 0}, 2);
    run_instr("adds_i", 2'b00, 6'b101001, 4'h3, '{0, 1, 7, 8, 0, 0, 0, 0}, 4);
    run_instr("mov_pc", 2'b00, 6'b011010, 4'hf, '{0, 1, 6, 8, 0, 0, 0, 0}, 4);
    run_instr("ldr",   2'b01, 6'b000001, 4'h4, '{0, 1, 2, 3, 3, 3, 4, 0}, 7);
    run_instr("ldr_pc", 2'b01, 6'b011001, 4'hf, '{0, 1, 2, 3, 3, 3, 4, 0}, 7);
    run_instr("str",   2'b01, 6'b000000, 4'hf, '{0, 1, 2, 5, 0, 0, 0, 0}, 4);
    run_instr("b",     2'b10, 6'b110000, 4'h0, '{0, 1, 9, 0, 0, 0, 0, 0}, 3);
    run_instr("nop",   2'b11, 6'b111111, 4'hf, '{0, 1, 0, 0, 0, 0, 0, 0}, 2);
    run_instr("subs_r", 2'b00, 6'b000101, 4'h2, '{0, 1, 6, 8, 0, 0, 0, 0}, 4);
    run_instr("orr_r", 2'b00, 6'b011000, 4'h1, '{0, 1, 6, 8, 0, 0, 0, 0}, 4);
    run_instr("ands_i", 2'b00, 6'b100001, 4'h5, '{0, 1, 7, 8, 0, 0, 0, 0}, 4);
    run_instr("orrs_i", 2'b00, 6'b111001, 4'h6, '{0, 1, 7, 8, 0, 0, 0, 0}, 4);
    run_instr("undef_r", 2'b00, 6'b001111, 4'h7, '{0, 1, 6, 8, 0, 0, 0, 0}, 4);

    reset_mid("rst_execr", 2'b00, 6'b000000, 4'h1, '{0, 1, 0, 0, 0, 0, 0, 0}, 2, 4'd6);
    run_instr("post_rst1", 2'b11, 6'b000000, 4'h0, '{0, 1, 0, 0, 0, 0, 0, 0}, 2);
    reset_mid("rst_aluwb", 2'b00, 6'b001000, 4'hf, '{0, 1, 6, 0, 0, 0, 0, 0}, 3, 4'd8);
    run_instr("post_rst2", 2'b10, 6'b000000, 4'h0, '{0, 1, 9, 0, 0, 0, 0, 0}, 3);
    reset_mid("rst_memw", 2'b01, 6'b000000, 4'h2, '{0, 1, 2, 0, 0, 0, 0, 0}, 3, 4'd5);
    run_instr("post_rst3", 2'b00, 6'b101000, 4'h3, '{0, 1, 7, 8, 0, 0, 0, 0}, 4);
    run_instr("tail",      2'b11, 6'b000000, 4'h0, '{0, 1, 0, 0, 0, 0, 0, 0}, 2);

    check_val("sb empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle build of the ARM-subset processor.
- Sequences the shared ALU, the unified instruction/data memory and the register file over several cycles per instruction: fetch, decode, execute, memory, writeback.
- Takes Op/Funct/Rd from the instruction register and drives datapath mux selects and write strobes.
- Drives ALU control and flag-write enables to the conditional-logic unit.

Parameters:
MEM_WAIT, 0, extra cycles held in MEMREAD before the load result is written back (0..15).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
Op  in  2  instruction bits [27:26], from IR
Funct  in  6  instruction bits [25:20], from IR
Rd  in  4  instruction bits [15:12], from IR
IRWrite  out  1  load instruction register
NextPC  out  1  PC increment write request
PCS  out  1  PC written by branch or by a write to R15
RegW  out  1  register-file write request
MemW  out  1  memory write request
AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register
ALUSrcA  out  2  00=register A, 01=PC, 10=ALU result register
ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4
ResultSrc  out  2  00=ALU result register, 01=data register, 10=ALU output
ImmSrc  out  2  equals Op
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
FlagW  out  2  [1]=NZ write enable, [0]=CV write enable
Mov  out  1  result is operand B (MOV)
State  out  4  current state encoding, for debug

Behaviour:
- Moore FSM. State register is the only storage besides the wait counter. All outputs are combinational from state, plus Funct for ALU decode and Rd for PCS.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
  - Codes 10..15 are illegal and return to FETCH on the next edge with all strobes low.
- Reset:
  - Synchronous. At the next edge, State=FETCH and the wait counter is 0.
  - While reset=1, IRWrite, NextPC, RegW, MemW and PCS are forced 0.
  - Other outputs show FETCH values once State=FETCH.
  - Reset asserted mid-instruction abandons it; no partial write occurs after the edge.
- FETCH:
  - AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Next state by opcode:
    - Op=00 with Funct[5]=0: EXECR.
    - Op=00 with Funct[5]=1: EXECI.
    - Op=01: MEMADR.
    - Op=10: BRANCH.
    - Op=11: FETCH (treated as NOP).
- MEMADR:
  - ALUSrcA=00, ALUSrcB=01, ALU forced to ADD.
  - Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD:
  - AdrSrc=1, ResultSrc=00.
  - Wait counter increments each cycle; go to MEMWB when counter==MEM_WAIT, clearing the counter.
- MEMWB: ResultSrc=01, RegW=1; next state FETCH.
- MEMWRITE: AdrSrc=1, MemW=1; next state FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALU decode active; next state ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALU decode active; next state ALUWB.
- ALUWB: ResultSrc=00, RegW=1; next state FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALU forced to ADD, PCS=1.
  - Next state: FETCH.
- PCS = Branch state OR (RegW AND Rd==1111).
- Unlisted outputs are 0 in each state.
- ALU decode is active only in EXECR/EXECI. On Funct[4:1]:
  - 0100: ADD, Mov=0.
  - 0010: SUB, Mov=0.
  - 0000: AND, Mov=0.
  - 1100: ORR, Mov=0.
  - 1101: ADD, Mov=1.
  - Any other value: ADD, Mov=0 (no X).
  - FlagW[1]=Funct[0].
  - FlagW[0]=Funct[0] AND (ALUControl is ADD or SUB).
- Outside EXECR/EXECI: ALUControl=000, FlagW=00, Mov=0.
- Cycle counts per instruction, reset release to next FETCH:
  - Data processing: 4.
  - STR: 4.
  - LDR: 5+MEM_WAIT.
  - B: 3.
  - Op=11: 2.

Test Plan:
- Reset held 2 cycles mid-EXECR, then released -> during reset IRWrite=RegW=MemW=0; first cycle after, State=0, IRWrite=1, NextPC=1, ALUSrcB=10.
- Op=00, Funct=101001 (ADDS imm), Rd=0011 -> states 0,1,7,8; in EXECI ALUControl=000, FlagW=11, ALUSrcB=01; in ALUWB RegW=1, PCS=0.
- Op=00, Funct=011010 (MOV reg), Rd=1111 -> states 0,1,6,8; Mov=1, FlagW=00; in ALUWB RegW=1, PCS=1.
- Op=01, Funct=000001 (LDR), MEM_WAIT=2 -> states 0,1,2,3,3,3,4 then 0; AdrSrc=1 in MEMREAD; MEMWB ResultSrc=01, RegW=1.
- Op=01, Funct=000000 (STR) -> states 0,1,2,5; MemW=1 for exactly one cycle; RegW never 1.
- Op=10 -> states 0,1,9,0; BRANCH PCS=1, ALUSrcA=10, ALUControl=000. Op=11 -> states 0,1,0 with no writes.
